// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the HI/LO reader and its scoreboard.
//   HILO_IDLE/HILO_WAIT/HILO_RESP : reader FSM encoding (2 bits)
//   HILO_SEL_HI / HILO_SEL_LO     : req_sel encoding (1 = HI, 0 = LO)
//   MAX_WR_LATENCY                : upper bound on the late-ALU write latency
package pipeline_pkg;

  localparam int unsigned MAX_WR_LATENCY = 8;
  localparam int unsigned HILO_DATA_W    = 32;

  localparam logic HILO_SEL_HI = 1'b1;
  localparam logic HILO_SEL_LO = 1'b0;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_WAIT = 2'd1,
    HILO_RESP = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_scoreboard.sv
// In-flight write tracker for one of the HI/LO registers.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_issue  : a late-ALU write to this register was accepted this cycle
//   pend_c    : combinational; a write issued this cycle or in the last
//               WR_LATENCY cycles may not have reached the register yet
module hilo_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_issue,
  output logic pend_c
);

  if (WR_LATENCY < 1 || WR_LATENCY > MAX_WR_LATENCY) begin : g_bad_latency
    $error("hilo_scoreboard: WR_LATENCY out of range 1..8");
  end

  logic [WR_LATENCY-1:0] sb_q;
  logic [WR_LATENCY-1:0] sb_d;

  // Shift the issue flag in; each bit marks one cycle of write flight time.
  if (WR_LATENCY == 1) begin : g_lat1
    always_comb sb_d = wr_issue;
  end else begin : g_latn
    always_comb sb_d = {sb_q[WR_LATENCY-2:0], wr_issue};
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // Includes the same-cycle issue; stays high one cycle past landing on purpose.
  assign pend_c = wr_issue | (|sb_q);

endmodule

// File: rtl/pipeline_hilo_reader.sv
// Consumer side of the HI/LO register pair: serves mfhi/mflo reads, stalling
// each read until all older late-ALU writes to the selected register landed.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_issue_hi/wr_issue_lo  : late-ALU write to HI/LO accepted this cycle
//   hi_in, lo_in             : current HI/LO register values
//   req_valid/req_sel/req_ready : read request (req_sel 1 = HI, 0 = LO)
//   rsp_valid/rsp_data/rsp_ready: one-entry response buffer
//   stall_cycles             : saturating WAIT cycle count, present only when
//                              PIPELINE_HILO_STALL_CNT_EN is defined
module pipeline_hilo_reader
  import pipeline_pkg::*;
#(
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_issue_hi,
  input  logic                   wr_issue_lo,
  input  logic [HILO_DATA_W-1:0] hi_in,
  input  logic [HILO_DATA_W-1:0] lo_in,
  input  logic                   req_valid,
  input  logic                   req_sel,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [HILO_DATA_W-1:0] rsp_data,
  input  logic                   rsp_ready
`ifdef PIPELINE_HILO_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int unsigned STALL_CNT_W = 32;

  logic pend_hi_c;
  logic pend_lo_c;

  hilo_scoreboard #(.WR_LATENCY(WR_LATENCY)) u_sb_hi (
    .clk      (clk),
    .rst      (rst),
    .wr_issue (wr_issue_hi),
    .pend_c   (pend_hi_c)
  );

  hilo_scoreboard #(.WR_LATENCY(WR_LATENCY)) u_sb_lo (
    .clk      (clk),
    .rst      (rst),
    .wr_issue (wr_issue_lo),
    .pend_c   (pend_lo_c)
  );

  hilo_state_e            state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [HILO_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                   cur_sel;
  logic                   pend_sel;
  logic [HILO_DATA_W-1:0] cur_val;

  // Next-state, capture and registered handshake outputs.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
    // In IDLE the incoming select decides; afterwards the latched one does.
    cur_sel    = (state_q == HILO_IDLE) ? req_sel : sel_q;
    pend_sel   = (cur_sel == HILO_SEL_HI) ? pend_hi_c : pend_lo_c;
    cur_val    = (cur_sel == HILO_SEL_HI) ? hi_in : lo_in;

    case (state_q)
      HILO_IDLE: begin
        if (req_valid && req_ready_q) begin
          sel_d = req_sel;
          if (!pend_sel) begin
            rsp_data_d = cur_val;
            state_d    = HILO_RESP;
          end else begin
            state_d = HILO_WAIT;
          end
        end
      end
      HILO_WAIT: begin
        if (!pend_sel) begin
          rsp_data_d = cur_val;
          state_d    = HILO_RESP;
        end
      end
      HILO_RESP: begin
        if (rsp_ready) state_d = HILO_IDLE;
      end
      default: state_d = HILO_IDLE;
    endcase

    req_ready_d = (state_d == HILO_IDLE);
    rsp_valid_d = (state_d == HILO_RESP);
  end

`ifdef PIPELINE_HILO_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Counts WAIT cycles still blocked by a pending write; saturates.
  always_comb begin
    stall_d = stall_q;
    if (state_q == HILO_WAIT && pend_sel && stall_q != {STALL_CNT_W{1'b1}}) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HILO_IDLE;
      sel_q       <= HILO_SEL_LO;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef PIPELINE_HILO_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef PIPELINE_HILO_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pipeline_hilo_reader.sv
// Bench for pipeline_hilo_reader: one instance at WR_LATENCY=3 for most
// scenarios and one at WR_LATENCY=1 for the single-cycle write case.
// Expected responses are queued when a request is driven and compared when
// the response appears. Inputs change just after the falling edge, outputs
// are sampled on the falling edge.
module tb_pipeline_hilo_reader;
  import pipeline_pkg::*;

  localparam int unsigned LAT      = 3;
  localparam int          MAX_WAIT = 40;

  logic        clk = 1'b0;
  logic        rst;

  logic        wr_issue_hi, wr_issue_lo;
  logic [31:0] hi_in, lo_in;
  logic        req_valid, req_sel, req_ready;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;

  logic        wr_issue_hi_1, wr_issue_lo_1;
  logic [31:0] hi_in_1, lo_in_1;
  logic        req_valid_1, req_sel_1, req_ready_1;
  logic        rsp_valid_1, rsp_ready_1;
  logic [31:0] rsp_data_1;

`ifdef PIPELINE_HILO_STALL_CNT_EN
  logic [31:0] stall_cycles, stall_cycles_1;
`endif

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hilo_reader #(.WR_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_issue_hi  (wr_issue_hi),
    .wr_issue_lo  (wr_issue_lo),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready)
`ifdef PIPELINE_HILO_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  pipeline_hilo_reader #(.WR_LATENCY(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .wr_issue_hi  (wr_issue_hi_1),
    .wr_issue_lo  (wr_issue_lo_1),
    .hi_in        (hi_in_1),
    .lo_in        (lo_in_1),
    .req_valid    (req_valid_1),
    .req_sel      (req_sel_1),
    .req_ready    (req_ready_1),
    .rsp_valid    (rsp_valid_1),
    .rsp_data     (rsp_data_1),
    .rsp_ready    (rsp_ready_1)
`ifdef PIPELINE_HILO_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles_1)
`endif
  );

  // Wait (bounded) for a response on the WR_LATENCY=3 instance.
  task automatic collect(output logic [31:0] d, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    d    = '0;
    while (!seen && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      req_valid   = 1'b0;
      wr_issue_hi = 1'b0;
      wr_issue_lo = 1'b0;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        d    = rsp_data;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_l3 got rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0",
               req_ready, rsp_valid, rsp_data);
    end
    checks++;
    if (req_ready_1 !== 1'b1 || rsp_valid_1 !== 1'b0 || rsp_data_1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_l1 got rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0",
               req_ready_1, rsp_valid_1, rsp_data_1);
    end
`ifdef PIPELINE_HILO_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", stall_cycles);
    end
`endif
  endtask

  task automatic test_idle_read();
    logic [31:0] d;
    int          lat;
    bit          seen;
    exp_t        e;
    repeat (4) @(negedge clk);
    hi_in     = 32'hDEADBEEF;
    req_valid = 1'b1;
    req_sel   = HILO_SEL_HI;
    rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_req_ready got %b want 1", req_ready);
    end
    exp_q.push_back('{32'hDEADBEEF, 1});
    collect(d, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++;
      $display("FAIL idle_latency got %0d (seen=%0d) want %0d", lat, seen, e.lat);
    end
    checks++;
    if (d !== e.data) begin
      errors++;
      $display("FAIL idle_data got %h want %h", d, e.data);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_hs got rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_mtlo_lat1();
    logic [31:0] d;
    int          lat;
    bit          seen;
    exp_t        e;
    repeat (4) @(negedge clk);
    lo_in_1       = 32'hAAAA0000;
    wr_issue_lo_1 = 1'b1;
    req_valid_1   = 1'b1;
    req_sel_1     = HILO_SEL_LO;
    rsp_ready_1   = 1'b1;
    // Pending t..t+1, capture in the first non-pending WAIT cycle t+2.
    exp_q.push_back('{32'h12345678, 3});
    lat  = 0;
    seen = 1'b0;
    d    = '0;
    while (!seen && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      wr_issue_lo_1 = 1'b0;
      req_valid_1   = 1'b0;
      if (lat == 1) lo_in_1 = 32'h12345678;
      if (rsp_valid_1 === 1'b1) begin
        seen = 1'b1;
        d    = rsp_data_1;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++;
      $display("FAIL mtlo_latency got %0d (seen=%0d) want %0d", lat, seen, e.lat);
    end
    checks++;
    if (d !== e.data) begin
      errors++;
      $display("FAIL mtlo_data got %h want %h", d, e.data);
    end
`ifdef PIPELINE_HILO_STALL_CNT_EN
    checks++;
    if (stall_cycles_1 !== 32'd1) begin
      errors++;
      $display("FAIL mtlo_stall got %0d want 1", stall_cycles_1);
    end
`endif
  endtask

  task automatic test_unrelated();
    logic [31:0] d;
    int          lat;
    bit          seen;
    exp_t        e;
    repeat (4) @(negedge clk);
    lo_in       = 32'h0BADF00D;
    hi_in       = 32'h99990000;
    wr_issue_hi = 1'b1;
    req_valid   = 1'b1;
    req_sel     = HILO_SEL_LO;
    exp_q.push_back('{32'h0BADF00D, 1});
    collect(d, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++;
      $display("FAIL unrelated_latency got %0d (seen=%0d) want %0d", lat, seen, e.lat);
    end
    checks++;
    if (d !== e.data) begin
      errors++;
      $display("FAIL unrelated_data got %h want %h", d, e.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] s0;
    int          lat;
    bit          seen;
    bit          ready_bad;
    exp_t        e;
    repeat (6) @(negedge clk);
    s0 = '0;
`ifdef PIPELINE_HILO_STALL_CNT_EN
    s0 = stall_cycles;
`endif
    hi_in       = 32'h11110000;
    wr_issue_hi = 1'b1;
    req_valid   = 1'b1;
    req_sel     = HILO_SEL_HI;
    // Issues at t and t+2 keep HI pending through t+5; response at t+7.
    exp_q.push_back('{32'h22220002, 7});
    lat       = 0;
    seen      = 1'b0;
    ready_bad = 1'b0;
    d         = '0;
    while (!seen && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      wr_issue_hi = (lat == 2);
      // Request inputs during WAIT must be ignored.
      req_valid   = (lat == 1);
      req_sel     = HILO_SEL_LO;
      if (lat == 3) hi_in = 32'h22220001;
      if (lat == 5) hi_in = 32'h22220002;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        d    = rsp_data;
      end else if (req_ready !== 1'b0) begin
        ready_bad = 1'b1;
      end
    end
    req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin
      errors++;
      $display("FAIL b2b_latency got %0d (seen=%0d) want %0d", lat, seen, e.lat);
    end
    checks++;
    if (d !== e.data) begin
      errors++;
      $display("FAIL b2b_data got %h want %h", d, e.data);
    end
    checks++;
    if (ready_bad) begin
      errors++;
      $display("FAIL b2b_req_ready got 1 during wait want 0");
    end
`ifdef PIPELINE_HILO_STALL_CNT_EN
    checks++;
    if (stall_cycles - s0 !== 32'd5) begin
      errors++;
      $display("FAIL b2b_stall got %0d want 5", stall_cycles - s0);
    end
`else
    s0 = s0;
`endif
  endtask

  task automatic test_backpressure();
    exp_t e;
    repeat (4) @(negedge clk);
    hi_in     = 32'hCAFE0001;
    lo_in     = 32'h5A5A0003;
    req_valid = 1'b1;
    req_sel   = HILO_SEL_HI;
    rsp_ready = 1'b0;
    exp_q.push_back('{32'hCAFE0001, 1});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        e = exp_q.pop_front();
        req_sel = HILO_SEL_LO;
        hi_in   = 32'hCAFE0002;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b data=%h rdy=%b want vld=1 data=%h rdy=0",
                 k, rsp_valid, rsp_data, req_ready, e.data);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_hs got rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
    // req_valid was held high; the LO request is taken in this IDLE cycle.
    exp_q.push_back('{32'h5A5A0003, 1});
    @(negedge clk);
    req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data) begin
      errors++;
      $display("FAIL bp_next_req got vld=%b data=%h want vld=1 data=%h", rsp_valid, rsp_data, e.data);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d;
    int          lat;
    bit          seen;
    exp_t        e;
    repeat (4) @(negedge clk);
    lo_in       = 32'h77770000;
    wr_issue_lo = 1'b1;
    req_valid   = 1'b1;
    req_sel     = HILO_SEL_LO;
    rsp_ready   = 1'b1;
    @(negedge clk);
    wr_issue_lo = 1'b0;
    req_valid   = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstw_in_wait got rdy=%b vld=%b want rdy=0 vld=0", req_ready, rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstw_after got rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
`ifdef PIPELINE_HILO_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL rstw_stall got %0d want 0", stall_cycles);
    end
`endif
    // The old LO write would still be pending here unless the scoreboard cleared.
    lo_in     = 32'h77770001;
    req_valid = 1'b1;
    req_sel   = HILO_SEL_LO;
    exp_q.push_back('{32'h77770001, 1});
    collect(d, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != e.lat || d !== e.data) begin
      errors++;
      $display("FAIL rstw_sb_clear got lat=%0d data=%h want lat=%0d data=%h", lat, d, e.lat, e.data);
    end
  endtask

  initial begin
    rst           = 1'b1;
    wr_issue_hi   = 1'b0;
    wr_issue_lo   = 1'b0;
    hi_in         = '0;
    lo_in         = '0;
    req_valid     = 1'b0;
    req_sel       = HILO_SEL_LO;
    rsp_ready     = 1'b1;
    wr_issue_hi_1 = 1'b0;
    wr_issue_lo_1 = 1'b0;
    hi_in_1       = '0;
    lo_in_1       = '0;
    req_valid_1   = 1'b0;
    req_sel_1     = HILO_SEL_LO;
    rsp_ready_1   = 1'b1;

    test_reset();
    test_idle_read();
    test_mtlo_lat1();
    test_unrelated();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
